// File: rtl/boolmin_sweep_checker.sv
// ---------------------------------------------------------------------------
// boolmin_sweep_checker
//
// Exhaustive sweep checker wrapped around the two-function minimised logic
// block. It walks all 256 values of the block's inputs {a,b,c,d,w,x,y,z}.
// It samples f1/f2 LAT cycles after each vector is driven and compares them
// against the original, unminimised sum-of-products expressions. It then
// reports per-function and combined mismatch counts, the first failing
// vector and ones-counts.
//
// Parameters:
//   LAT   cycles between driving a vector and sampling f1/f2 (0..15).
//         0 samples in the same cycle the vector is driven.
//
// Ports:
//   clk, rst            clock (rising edge) / async active-high reset
//   start               one-cycle sweep request, honoured in IDLE or DONE
//   abort               stop a sweep (or clear done) and return to IDLE
//   f1, f2              outputs of the block under test
//   a,b,c,d,w,x,y,z     registered stimulus vec[7:0], a = MSB
//   busy                sweep in progress
//   done                level, sweep completed, cleared by start/abort
//   pass                done and no mismatching vector
//   err_cnt             vectors with an f1 or f2 mismatch
//   err1_cnt, err2_cnt  per-function mismatch counts
//   first_fail_vec      first mismatching vector (valid with first_fail_valid)
//   f1_ones, f2_ones    number of sampled ones on f1 / f2
// ---------------------------------------------------------------------------
module boolmin_sweep_checker #(
    parameter int LAT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       f1,
    input  logic       f2,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d,
    output logic       w,
    output logic       x,
    output logic       y,
    output logic       z,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [8:0] err_cnt,
    output logic [8:0] err1_cnt,
    output logic [8:0] err2_cnt,
    output logic [7:0] first_fail_vec,
    output logic       first_fail_valid,
    output logic [8:0] f1_ones,
    output logic [8:0] f2_ones
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    // With LAT = 0 there is nothing to wait for, so every vector goes
    // straight to SAMPLE.
    localparam state_t     VEC_ST      = (LAT == 0) ? SAMPLE : SETTLE;
    localparam logic [3:0] SETTLE_LAST = (LAT > 0) ? 4'(LAT - 1) : 4'd0;

    state_t     state, state_next;
    logic [7:0] vec;
    logic [3:0] settle_cnt;

    // Control strobes produced by the next-state logic.
    logic clear;      // start accepted: wipe results, rewind vec
    logic do_sample;  // score f1/f2 for the current vec
    logic advance;    // step to the next vector

    // -----------------------------------------------------------------------
    // Golden functions, written exactly as the original unminimised SOPs.
    // -----------------------------------------------------------------------
    logic va, vb, vc, vd, vw, vx, vy, vz;
    logic g1, g2;
    logic m1, m2;

    assign {va, vb, vc, vd, vw, vx, vy, vz} = vec;

    assign g1 = (~va & ~vb & ~vc & ~vd) |
                ( va & ~vc & ~vd)       |
                (~vb &  vc & ~vd)       |
                (~va &  vb &  vc &  vd) |
                ( vb & ~vc &  vd);

    assign g2 = ( vx & ~vy &  vz) |
                (~vx & ~vy &  vz) |
                (~vw &  vx &  vy) |
                ( vw & ~vx &  vy) |
                ( vw &  vx &  vy);

    assign m1 = f1 ^ g1;
    assign m2 = f2 ^ g2;

    // -----------------------------------------------------------------------
    // FSM state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // -----------------------------------------------------------------------
    // Next-state and control strobes. abort beats start everywhere.
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state;
        clear      = 1'b0;
        do_sample  = 1'b0;
        advance    = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                // abort here only matters in DONE, where it drops done.
                if (abort) begin
                    state_next = IDLE;
                end else if (start) begin
                    state_next = VEC_ST;
                    clear      = 1'b1;
                end
            end
            SETTLE: begin
                if (abort)                          state_next = IDLE;
                else if (settle_cnt == SETTLE_LAST) state_next = SAMPLE;
            end
            SAMPLE: begin
                if (abort) begin
                    // The vector being sampled is dropped, so the partial
                    // counts cover only fully scored vectors.
                    state_next = IDLE;
                end else begin
                    do_sample = 1'b1;
                    if (vec == 8'hFF) begin
                        state_next = DONE;
                    end else begin
                        advance    = 1'b1;
                        state_next = VEC_ST;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Settle counter: counts cycles spent in SETTLE for the current vector.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            settle_cnt <= 4'd0;
        else if (state == SETTLE && state_next == SETTLE)
            settle_cnt <= settle_cnt + 4'd1;
        else
            settle_cnt <= 4'd0;
    end

    // -----------------------------------------------------------------------
    // Stimulus vector and result counters
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vec              <= 8'h00;
            err_cnt          <= 9'd0;
            err1_cnt         <= 9'd0;
            err2_cnt         <= 9'd0;
            first_fail_vec   <= 8'h00;
            first_fail_valid <= 1'b0;
            f1_ones          <= 9'd0;
            f2_ones          <= 9'd0;
        end else if (clear) begin
            vec              <= 8'h00;
            err_cnt          <= 9'd0;
            err1_cnt         <= 9'd0;
            err2_cnt         <= 9'd0;
            first_fail_vec   <= 8'h00;
            first_fail_valid <= 1'b0;
            f1_ones          <= 9'd0;
            f2_ones          <= 9'd0;
        end else begin
            if (do_sample) begin
                err1_cnt <= err1_cnt + 9'(m1);
                err2_cnt <= err2_cnt + 9'(m2);
                // One count per vector even when both functions disagree.
                err_cnt  <= err_cnt + 9'(m1 | m2);
                f1_ones  <= f1_ones + 9'(f1);
                f2_ones  <= f2_ones + 9'(f2);
                if ((m1 | m2) && !first_fail_valid) begin
                    first_fail_vec   <= vec;
                    first_fail_valid <= 1'b1;
                end
            end
            // The sweep ends at 0xFF, so vec never wraps.
            if (advance) vec <= vec + 8'd1;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign {a, b, c, d, w, x, y, z} = vec;
    assign busy = (state == SETTLE) || (state == SAMPLE);
    assign done = (state == DONE);
    assign pass = done && (err_cnt == 9'd0);

endmodule

// File: doc/boolmin_sweep_checker.md
Name: boolmin_sweep_checker

Overview:
- Sequential exhaustive-sweep checker that sits directly around the two-function minimised logic block.
- It drives all 256 combinations of the block's eight inputs a,b,c,d,w,x,y,z and captures its outputs f1 and f2.
- It compares the captured outputs against internally computed unminimised golden SOP expressions, and reports mismatch counts, the first failing vector and ones-counts.
- Used on board and in regression to prove the minimised logic equivalent to the original expressions.

Parameters:
- LAT, 1, cycles between driving a vector and sampling f1/f2; legal range 0..15; 0 = sample in the same cycle the vector is driven.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- start  input  1  one-cycle request to begin a sweep; honoured only in IDLE or DONE.
- abort  input  1  terminates a sweep in progress; returns to IDLE without asserting done.
- f1  input  1  f1 output of the minimised block.
- f2  input  1  f2 output of the minimised block.
- a,b,c,d  output  1 each  registered stimulus, vec[7:4] (a = MSB).
- w,x,y,z  output  1 each  registered stimulus, vec[3:0] (w = MSB).
- busy  output  1  high while sweeping.
- done  output  1  level; high from sweep completion until the next start or abort.
- pass  output  1  valid when done=1; 1 iff err_cnt == 0.
- err_cnt  output  9  vectors where f1 or f2 mismatched (0..256).
- err1_cnt  output  9  f1 mismatches.
- err2_cnt  output  9  f2 mismatches.
- first_fail_vec  output  8  vec of the first mismatching vector.
- first_fail_valid  output  1  first_fail_vec holds a captured value.
- f1_ones  output  9  count of sampled f1 = 1.
- f2_ones  output  9  count of sampled f2 = 1.

Behaviour:
- Golden f1 = a'b'c'd' + ac'd' + b'cd' + a'bcd + bc'd, giving abcd minterms {0,2,5,7,8,10,12,13}.
- Golden f2 = xy'z + x'y'z + w'xy + wx'y + wxy, giving wxyz minterms {1,5,6,7,9,10,11,13,14,15}.
- Golden values are computed combinationally from the current vec. They are never taken from the DUT.
- Reset values (async on rst high): all outputs 0, vec = 0x00, counters 0, state IDLE.
- FSM states:
  - IDLE: waits for start. On start: clears all counters, first_fail_valid and done; sets vec = 0x00 and busy = 1; goes to SETTLE.
  - SETTLE: holds vec for LAT cycles. With LAT = 0 it is skipped; transitions go directly to SAMPLE.
  - SAMPLE (one cycle):
    - Compares f1/f2 with golden and updates err1_cnt, err2_cnt, err_cnt (+1 at most per vector) and f1_ones/f2_ones.
    - On the first mismatch, captures first_fail_vec = vec and sets first_fail_valid = 1.
    - If vec == 0xFF, goes to DONE with vec held at 0xFF. Otherwise vec increments and the FSM returns to SETTLE (or SAMPLE when LAT = 0).
  - DONE: busy = 0, done = 1; results held stable. start restarts exactly as from IDLE.
- Timing:
  - Vector v is visible on a..z in cycle t; f1/f2 are sampled on the rising edge ending cycle t + LAT; vector v+1 is visible in cycle t + LAT + 1.
  - A sweep takes 256·(LAT+1) cycles after the start-accept cycle.
- start while busy: ignored, with no restart and no counter disturbance.
- abort: if busy, goes to IDLE at the next edge with busy = 0, done = 0; counters hold their partial values. abort has priority over start in the same cycle. abort in IDLE or DONE: clears done only.
- rst mid-sweep: immediate return to reset values; no partial results retained.
- Counters are 9 bits and cannot overflow (maximum 256). vec wrap from 0xFF never occurs, because the sweep terminates at 0xFF.
- f1/f2 are sampled only in SAMPLE; their values in other states are don't-care.

Test Plan:
- Correct minimised DUT connected, LAT = 1, start pulse:
  - done rises 512 cycles after accept.
  - pass = 1, err_cnt = 0, first_fail_valid = 0.
  - f1_ones = 128, f2_ones = 160.
- f1 forced stuck-at-0:
  - err1_cnt = 128, err2_cnt = 0, err_cnt = 128.
  - first_fail_vec = 0x00, pass = 0.
- f2 forced stuck-at-0:
  - err2_cnt = 160, err_cnt = 160, first_fail_vec = 0x01.
  - f2_ones = 0.
- f1 and f2 both inverted, LAT = 0:
  - done after 256 cycles.
  - err_cnt = 256, err1_cnt = 256, err2_cnt = 256, first_fail_vec = 0x00.
- start re-pulsed at vec = 0x40: ignored, and the final counts match the uninterrupted run.
- abort at vec = 0x80: returns to IDLE with done = 0.
- rst asserted mid-sweep: all outputs 0 asynchronously; a new start then completes normally.
